// File: rtl/tmr_pipe.sv
// -----------------------------------------------------------------------------
// tmr_pipe: DEPTH-stage, W-bit pipelined register chain with a valid/ready
// handshake and selective triple modular redundancy.
//
// Every stage keeps three copies of its valid bit. It also keeps three copies
// of each data bit selected by TRIPLICATE, and one copy of every other data
// bit. All handshake and output logic works on the voted view. A stage that
// does not load rewrites all of its copies with its own voted value every
// cycle (scrub), so a single upset is gone after the next edge. Any
// disagreement between copies anywhere in the chain raises a combinational
// mismatch flag. That flag drives a registered error pulse and a saturating
// error counter.
//
// Optional build macro:
//   TMR_PIPE_ERR_INJECT_EN - adds inj_en / inj_stage / inj_bit. These ports
//                            invert the value stored into copy 0 of one data
//                            bit of one stage. Out-of-range indices are ignored.
//
// Ports:
//   clk        in   1   clock
//   rstn       in   1   asynchronous active-low reset
//   en         in   1   global advance enable (0 freezes the chain, scrub runs)
//   in_valid   in   1   upstream word valid
//   in_ready   out  1   stage 0 can accept
//   in_data    in   W   upstream word
//   out_valid  out  1   voted valid of the last stage
//   out_ready  in   1   downstream accepts
//   out_data   out  W   voted data of the last stage
//   err        out  1   a copy mismatch existed during the previous cycle
//   err_cnt    out  CW  saturating count of mismatch cycles
//   clr_err    in   1   synchronous clear of err_cnt (wins over a mismatch)
//   inj_en     in   1   (macro only) fault-injection strobe
//   inj_stage  in   max(1,clog2(DEPTH))  (macro only) target stage
//   inj_bit    in   max(1,clog2(W))      (macro only) target data bit
// -----------------------------------------------------------------------------
module tmr_pipe #(
    parameter int             W          = 10,
    parameter int             DEPTH      = 3,
    parameter logic [W-1:0]   TRIPLICATE = 10'b0101010101,
    parameter logic [W-1:0]   RESET_VAL  = '0,
    parameter int             CW         = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    input  logic          clr_err
`ifdef TMR_PIPE_ERR_INJECT_EN
    ,
    input  logic                                        inj_en,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] inj_stage,
    input  logic [((W > 1) ? $clog2(W) : 1)-1:0]         inj_bit
`endif
);

    // -------------------------------------------------------------------------
    // Storage: three data copies and three valid copies per stage.
    // Copies 1 and 2 of single (non-triplicated) bits are tied to RESET_VAL.
    // Those flops are constant and drop out in synthesis.
    // -------------------------------------------------------------------------
    logic [W-1:0]     c0_q [DEPTH];
    logic [W-1:0]     c1_q [DEPTH];
    logic [W-1:0]     c2_q [DEPTH];
    logic [W-1:0]     c0_d [DEPTH];
    logic [W-1:0]     c1_d [DEPTH];
    logic [W-1:0]     c2_d [DEPTH];
    logic [DEPTH-1:0] v0_q, v1_q, v2_q;
    logic [DEPTH-1:0] v_d;

    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Voted view of every stage.
    logic [W-1:0]     vd [DEPTH];
    logic [DEPTH-1:0] vv;

    // Upstream value each stage would load.
    logic [W-1:0]     up_d [DEPTH];
    logic [DEPTH-1:0] up_v;

    logic [DEPTH-1:0] rdy;
    logic             mm;

    // Per-stage XOR mask applied to copy 0 only (fault injection).
    logic [W-1:0]     flip [DEPTH];

    function automatic logic [W-1:0] maj3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // -------------------------------------------------------------------------
    // Voting. A single bit is simply copy 0.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // logic, so no path can leave a value unassigned and infer a latch.
        vv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vd[i] = (TRIPLICATE & maj3(c0_q[i], c1_q[i], c2_q[i]))
                  | (~TRIPLICATE & c0_q[i]);
            vv[i] = (v0_q[i] & v1_q[i]) | (v0_q[i] & v2_q[i]) | (v1_q[i] & v2_q[i]);
        end
    end

    // -------------------------------------------------------------------------
    // Ready chain, evaluated from the output backwards.
    // rdy[i] = en & (!v[i] | rdy[i+1]), with out_ready standing in for rdy[DEPTH].
    // -------------------------------------------------------------------------
    always_comb begin
        logic r;
        rdy = '0;
        r   = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = en & (~vv[i] | r);
            rdy[i] = r;
        end
    end

    // -------------------------------------------------------------------------
    // Upstream source for each stage: the input port feeds stage 0, and the
    // voted previous stage feeds the others. The value is loaded even when it
    // is marked invalid.
    // -------------------------------------------------------------------------
    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = vv[i-1];
            up_d[i] = vd[i-1];
        end
    end

    // -------------------------------------------------------------------------
    // Fault injection mask.
    // -------------------------------------------------------------------------
`ifdef TMR_PIPE_ERR_INJECT_EN
    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            flip[i] = '0;
            if (inj_en && (int'(inj_stage) == i) && (int'(inj_bit) < W)) begin
                flip[i] = ONE << inj_bit;
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            flip[i] = '0;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next state. A loading stage takes its upstream value. A holding stage
    // takes its own voted value, and this rewrite is the scrub. All copies get
    // the same word, except that copy 0 may be inverted by the injection mask.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [W-1:0] nd;
        v_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nd      = rdy[i] ? up_d[i] : vd[i];
            v_d[i]  = rdy[i] ? up_v[i] : vv[i];
            c0_d[i] = nd ^ flip[i];
            c1_d[i] = (nd & TRIPLICATE) | (RESET_VAL & ~TRIPLICATE);
            c2_d[i] = (nd & TRIPLICATE) | (RESET_VAL & ~TRIPLICATE);
        end
    end

    // -------------------------------------------------------------------------
    // Mismatch detection: a triplicated data bit or a valid bit, in any stage,
    // whose three copies are not all equal.
    // -------------------------------------------------------------------------
    always_comb begin
        mm = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mm = mm | (|(((c0_q[i] ^ c1_q[i]) | (c0_q[i] ^ c2_q[i])) & TRIPLICATE));
        end
        mm = mm | (|((v0_q ^ v1_q) | (v0_q ^ v2_q)));
    end

    // -------------------------------------------------------------------------
    // Error pulse and saturating counter. Clear takes priority over a mismatch.
    // -------------------------------------------------------------------------
    always_comb begin
        err_d = mm;
        cnt_d = cnt_q;
        if (clr_err) begin
            cnt_d = '0;
        end else if (mm && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: the copy arrays are reset like any other register. A pipeline
    // stage must come out of reset with defined, mutually consistent copies,
    // or the mismatch detector would fire on garbage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                c0_q[i] <= RESET_VAL;
                c1_q[i] <= RESET_VAL;
                c2_q[i] <= RESET_VAL;
            end
            v0_q  <= '0;
            v1_q  <= '0;
            v2_q  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every stage samples the
            // pre-edge voted state of its neighbour and the chain shifts by
            // exactly one position per edge.
            for (int i = 0; i < DEPTH; i++) begin
                c0_q[i] <= c0_d[i];
                c1_q[i] <= c1_d[i];
                c2_q[i] <= c2_d[i];
            end
            v0_q  <= v_d;
            v1_q  <= v_d;
            v2_q  <= v_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    assign in_ready  = rdy[0];
    assign out_valid = vv[DEPTH-1];
    assign out_data  = vd[DEPTH-1];
    assign err       = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_tmr_pipe.sv
// -----------------------------------------------------------------------------
// tb_tmr_pipe: self-checking bench for tmr_pipe.
// The bench applies a directed sequence and then a randomized stream. The
// random stream is scored against a FIFO ordering model. The injection tests
// run only when TMR_PIPE_ERR_INJECT_EN is defined.
// -----------------------------------------------------------------------------
module tb_tmr_pipe;

    localparam int W     = 10;
    localparam int DEPTH = 3;
    localparam int CW    = 8;

    logic          clk;
    logic          rstn;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          err;
    logic [CW-1:0] err_cnt;
    logic          clr_err;
`ifdef TMR_PIPE_ERR_INJECT_EN
    logic          inj_en;
    logic [1:0]    inj_stage;
    logic [3:0]    inj_bit;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] sb_q[$];

    tmr_pipe #(
        .W          (W),
        .DEPTH      (DEPTH),
        .TRIPLICATE (10'b0101010101),
        .RESET_VAL  (10'h000),
        .CW         (CW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .err_cnt   (err_cnt),
        .clr_err   (clr_err)
`ifdef TMR_PIPE_ERR_INJECT_EN
        ,
        .inj_en    (inj_en),
        .inj_stage (inj_stage),
        .inj_bit   (inj_bit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn      = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
`ifdef TMR_PIPE_ERR_INJECT_EN
        inj_en    = 1'b0;
        inj_stage = '0;
        inj_bit   = '0;
`endif
        #1;
        // ---------------- reset state ----------------
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        en = 1'b0;
        #1;
        check("rst_in_ready_en0", in_ready, 0);
        en = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- back-to-back stream, latency DEPTH-1 ----------------
        in_valid = 1'b1;
        in_data  = 10'h155;
        tick();                         // 0x155 accepted
        check("lat_e0_valid", out_valid, 0);
        in_data = 10'h2AA;
        tick();
        check("lat_e1_valid", out_valid, 0);
        in_data = 10'h3FF;
        tick();                         // two edges after the accept
        check("lat_w0_valid", out_valid, 1);
        check("lat_w0_data", out_data, 10'h155);
        in_valid = 1'b0;
        tick();
        check("lat_w1_data", out_data, 10'h2AA);
        tick();
        check("lat_w2_data", out_data, 10'h3FF);
        check("lat_w2_valid", out_valid, 1);
        tick();
        check("lat_drained", out_valid, 0);
        check("lat_err", err, 0);
        check("lat_err_cnt", err_cnt, 0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 10'h011;
        tick();
        in_data = 10'h022;
        tick();
        in_data = 10'h033;
        tick();
        in_data = 10'h044;
        #1;
        check("bp_full_in_ready", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
        check("bp_full_data", out_data, 10'h011);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_data", out_data, 10'h011);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_w1", out_data, 10'h022);
        tick();
        check("bp_w2", out_data, 10'h033);
        tick();
        check("bp_w3", out_data, 10'h044);
        tick();
        check("bp_drained", out_valid, 0);

        // ---------------- en = 0 freeze ----------------
        in_valid = 1'b1;
        in_data  = 10'h101;
        tick();
        in_data = 10'h0F0;
        tick();
        in_data = 10'h20F;
        tick();
        check("en_pre_data", out_data, 10'h101);
        en      = 1'b0;
        in_data = 10'h3C3;
        #1;
        check("en_off_in_ready", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("en_off_in_ready", in_ready, 0);
            check("en_off_valid", out_valid, 1);
            check("en_off_data", out_data, 10'h101);
        end
        en = 1'b1;
        #1;
        check("en_on_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("en_w1", out_data, 10'h0F0);
        tick();
        check("en_w2", out_data, 10'h20F);
        tick();
        check("en_w3", out_data, 10'h3C3);
        tick();
        check("en_drained", out_valid, 0);

        // ---------------- asynchronous reset mid-transfer ----------------
        in_valid = 1'b1;
        in_data  = 10'h2D2;
        tick();
        tick();
        tick();
        check("mid_pre_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("mid_after_valid", out_valid, 0);

`ifdef TMR_PIPE_ERR_INJECT_EN
        // ---------------- injection into a triplicated bit ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 10'h155;
        tick();
        in_valid = 1'b0;
        tick();                         // word now in stage 1
        en        = 1'b0;
        inj_en    = 1'b1;
        inj_stage = 2'd1;
        inj_bit   = 4'd0;
        tick();
        inj_en = 1'b0;
        check("inj_t_err_0", err, 0);
        tick();
        check("inj_t_err_1", err, 1);
        check("inj_t_cnt_1", err_cnt, 1);
        tick();
        check("inj_t_err_2", err, 0);
        check("inj_t_cnt_2", err_cnt, 1);
        en = 1'b1;
        tick();
        check("inj_t_valid", out_valid, 1);
        check("inj_t_data", out_data, 10'h155);

        // ---------------- injection into a single bit ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 10'h155;
        tick();
        in_valid = 1'b0;
        tick();
        en        = 1'b0;
        inj_en    = 1'b1;
        inj_stage = 2'd1;
        inj_bit   = 4'd1;
        tick();
        inj_en = 1'b0;
        tick();
        check("inj_s_err_1", err, 0);
        tick();
        check("inj_s_err_2", err, 0);
        en = 1'b1;
        tick();
        check("inj_s_data", out_data, 10'h157);
        check("inj_s_cnt", err_cnt, 0);

        // ---------------- out-of-range index is ignored ----------------
        do_reset();
        en        = 1'b0;
        inj_en    = 1'b1;
        inj_stage = 2'd3;
        inj_bit   = 4'd0;
        tick();
        inj_stage = 2'd0;
        inj_bit   = 4'd12;
        tick();
        inj_en = 1'b0;
        tick();
        check("inj_oor_cnt", err_cnt, 0);
        en = 1'b1;

        // ---------------- counter saturation and clear ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 10'h155;
        tick();
        in_valid = 1'b0;
        tick();
        en        = 1'b0;
        inj_en    = 1'b1;
        inj_stage = 2'd1;
        inj_bit   = 4'd0;
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            tick();
        end
        check("sat_cnt", err_cnt, 255);
        check("sat_err", err, 1);
        clr_err = 1'b1;                 // mismatch still present this cycle
        tick();
        check("sat_clr_cnt", err_cnt, 0);
        clr_err = 1'b0;
        inj_en  = 1'b0;
        tick();
        check("sat_post_cnt", err_cnt, 1);
        tick();
        check("sat_post_err", err, 0);
        en = 1'b1;
`endif

        // ---------------- randomized stream vs FIFO model ----------------
        do_reset();
        check("rand_start_cnt", err_cnt, 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = W'($urandom_range(0, (1 << W) - 1));
            clr_err   = ($urandom_range(0, 31) == 0);
            #1;
            if (!en) check("rand_en0_in_ready", in_ready, 0);
            if (en && out_ready) check("rand_flow_in_ready", in_ready, 1);
            if (en && sb_q.size() == 0) check("rand_empty_in_ready", in_ready, 1);
            if (out_valid) begin
                check("rand_valid_has_word", (sb_q.size() > 0), 1);
                if (sb_q.size() > 0) check("rand_data", out_data, sb_q[0]);
            end
            check("rand_err", err, 0);
            if (out_valid && out_ready && en && sb_q.size() > 0) void'(sb_q.pop_front());
            if (in_valid && in_ready) sb_q.push_back(in_data);
            check("rand_occupancy", (sb_q.size() <= DEPTH), 1);
            tick();
        end

        // Drain whatever is still in flight, with a bounded budget.
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        for (int cyc = 0; cyc < 4 * DEPTH && sb_q.size() > 0; cyc++) begin
            #1;
            if (out_valid) begin
                check("drain_data", out_data, sb_q[0]);
                void'(sb_q.pop_front());
            end
            tick();
        end
        check("drain_empty", sb_q.size(), 0);
        check("drain_valid", out_valid, 0);
        check("final_err_cnt", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmr_pipe.md
Name: tmr_pipe

Overview:
- DEPTH-stage, W-bit pipelined register chain with a valid/ready handshake; the next generation of the team's per-bit TMR register.
- Each data bit is selectively triplicated by a mask. Each stage's valid bit is always triplicated.
- Triplicated bits are majority-voted, continuously scrubbed and monitored for copy mismatches. Mismatches drive an error pulse and a saturating error counter.
- Used for SEU-hardened datapath staging between compute blocks.

Parameters:
- W, 10, data width in bits.
- DEPTH, 3, number of pipeline stages (>=1).
- TRIPLICATE, 10'b0101010101, W-bit mask; 1 = bit triplicated, 0 = single flop.
- RESET_VAL, 0, W-bit reset value for every stage's data copies.
- CW, 8, width of the error counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  global advance enable; 0 freezes the pipeline.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage 0 can accept.
- in_data  in  W  upstream word.
- out_valid  out  1  voted valid of the last stage.
- out_ready  in  1  downstream accepts.
- out_data  out  W  voted data of the last stage.
- err  out  1  registered pulse: a mismatch was detected on the previous cycle.
- err_cnt  out  CW  saturating count of mismatch cycles.
- clr_err  in  1  synchronous clear of err_cnt.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values:
  - all data copies = RESET_VAL;
  - all valid copies = 0;
  - err = 0, err_cnt = 0;
  - out_valid = 0, out_data = RESET_VAL, in_ready = en.
- Voted value:
  - triplicated bit = maj(c0, c1, c2);
  - single bit = its flop;
  - stage valid = maj of its 3 copies.
  - All handshake and output logic uses voted values only.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready;
  - rdy[i] = en & (!v[i] | rdy[i+1]);
  - in_ready = rdy[0].
- Stage i loads when rdy[i] = 1:
  - stage 0 loads {in_valid, in_data};
  - stage i>0 loads {v[i-1], d[i-1]} (voted).
  - All copies receive the same value.
- Stage not loading: every copy is rewritten with the stage's own voted value (scrub). A single upset is therefore corrected at the next edge.
- Data loaded from an invalid upstream is don't-care, but it is still loaded.
- Latency: a word accepted at edge N appears on out_valid after edge N+DEPTH-1 when there is no backpressure. Throughput is 1 word/cycle.
- en = 0: no stage loads, in_ready = 0, scrubbing continues, outputs hold.
- out_ready = 0 while out_valid = 1: the last stage holds. Bubbles upstream still collapse.
- Mismatch (mm): any triplicated data bit or any valid bit, in any stage, whose three copies are not all equal (combinational OR).
- err <= mm at every edge.
- err_cnt update:
  - clr_err = 1: err_cnt <= 0 (clear wins over a simultaneous mm);
  - else if mm and err_cnt != all-ones: err_cnt <= err_cnt + 1;
  - at all-ones it holds.
- A double upset in one bit is voted wrong and propagates. It is flagged once, then scrubbed to a consistent value. Correction of double upsets is not required.
- Reset asserted mid-transfer: all in-flight words are discarded immediately (asynchronous). No output glitch is required beyond going to reset values.

Optional Feature:
- Macro: TMR_PIPE_ERR_INJECT_EN.
- Defined: adds ports
  - inj_en  in  1;
  - inj_stage  in  max(1,$clog2(DEPTH));
  - inj_bit  in  max(1,$clog2(W)).
- With inj_en = 1 at an edge, copy 0 of data bit inj_bit in stage inj_stage stores the inverse of the value it would otherwise store.
  - Triplicated bit: gives mm on the next cycle, err the cycle after, and is corrected by scrub.
  - Single bit: the flip persists, with no err.
  - Out-of-range index: ignored.
- Undefined: the ports and logic are absent, and behaviour is identical to inj_en = 0.

Test Plan:
- Reset, then in_valid = 1 with data 0x155, 0x2AA, 0x3FF on consecutive cycles and out_ready = 1 -> out_data shows 0x155, 0x2AA, 0x3FF on consecutive cycles, starting DEPTH-1 = 2 edges after the 0x155 accept; err stays 0.
- Fill 3 words, out_ready = 0 for 5 cycles -> in_ready = 0 after the pipe fills; out_data is held at the first word; no word is lost or duplicated after release.
- en = 0 for 4 cycles mid-stream -> in_ready = 0, outputs frozen; the stream resumes intact when en = 1.
- Inject (macro on) on stage 1, bit 0 (triplicated), value 0x155 -> err = 1 for exactly one cycle; err_cnt = 1; out_data = 0x155 unchanged.
- Inject on bit 1 (single flop) of stage 1 holding 0x155 -> out_data = 0x157 for that word; err stays 0.
- Force 2^CW + 3 mismatch cycles -> err_cnt saturates at 255; clr_err pulse together with mm -> err_cnt = 0.
